nn_layer1_mac_neuron: RTL and testbench
=======================================

Name: nn_layer1_mac_neuron

Overview:
Single-neuron multiply-accumulate stage for layer 1. It sits directly downstream of the layer-1 input counter. It consumes the same per-input strobe `ack` with its data sample. On each accepted sample it multiplies the sample by a stored weight and accumulates the product. When the counter raises `ack_mac`, it adds the bias, applies ReLU, saturates, and presents the neuron output to the next layer on a valid/ready handshake.

Parameters:
N_IN, 3, number of inputs per neuron; must match the counter's terminal count (q==N_IN-1).
DATA_W, 8, signed width of input, weight, bias and output (two's complement).
FRAC_W, 4, fractional bits of the fixed-point format, shared by all data.
ACC_W, 20, signed accumulator width; must be ≥ 2*DATA_W+clog2(N_IN)+1.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset, synchronous, active-high.
ack  in  1  input-sample strobe, same signal that drives the counter.
x_in  in  DATA_W  signed input sample, valid when ack=1.
ack_mac  in  1  from layer-1 counter; sticky high once all inputs are counted; updates on negedge.
w_wr  in  1  weight/bias write enable (only honoured in IDLE).
w_addr  in  clog2(N_IN+1)  0..N_IN-1 selects a weight; N_IN selects the bias.
w_data  in  DATA_W  write data.
y_out  out  DATA_W  neuron output, Q(DATA_W-FRAC_W).FRAC_W, ≥0.
y_valid  out  1  y_out valid.
y_ready  in  1  downstream accepts y_out.
busy  out  1  high in any state other than IDLE.
ovf  out  1  sticky: extra ack received after N_IN samples, before ack_mac.

Behaviour:
- Reset: state=IDLE, acc=0, idx=0, ack_mac_d=0, y_out=0, y_valid=0, ovf=0. Weight and bias registers are NOT cleared.
- `ack_mac` edge detection: ack_mac_d is registered each posedge; rise = ack_mac & ~ack_mac_d. The counter holds `ack_mac` high until `rst`, so only the rising edge triggers.
- IDLE:
  - w_wr writes weight[w_addr] or bias. Writes are ignored in other states, and addresses > N_IN are ignored.
  - ack=1 → acc ← sext(x_in*weight[0]), idx ← 1, go to ACCUM.
- ACCUM:
  - ack=1 with idx<N_IN → acc ← acc + sext(x_in*weight[idx]), idx++.
  - ack=1 with idx==N_IN → no accumulate, ovf ← 1.
- Any state except OUT: rise=1 → go to BIAS at the next posedge. An ack in the same cycle is still accumulated first (per the ACCUM/IDLE rules).
- BIAS, 1 cycle: acc ← acc + (sext(bias) << FRAC_W), go to ACT.
- ACT, 1 cycle:
  - t = acc >>> FRAC_W (arithmetic, truncating).
  - y_out ← 0 if t<0; (2^(DATA_W-1))-1 if t exceeds it; else t[DATA_W-1:0].
  - y_valid ← 1, go to OUT.
- OUT:
  - Hold y_out and y_valid until y_ready=1.
  - On y_ready: y_valid ← 0, acc ← 0, idx ← 0, go to IDLE.
  - ack during OUT is ignored; rise during OUT is ignored.
- Latency: rise sampled → y_valid high 2 cycles later (BIAS, ACT), assuming no backpressure.
- Products: 2*DATA_W signed, sign-extended to ACC_W. The accumulator is sized so it cannot wrap for legal N_IN.
- rst mid-operation (any state) returns to reset values at the next posedge. Any pending result is discarded.
- rst and ack together: rst wins.

Test Plan:
- Reset, then load w0=16, w1=32, w2=-16, bias=16; three acks with x=16 → acc=512 → 768 after bias → y_out=48, y_valid 2 cycles after rise, busy=1 throughout.
- Weights all -16, bias 0, x=16 ×3 → t=-48 → ReLU gives y_out=0, y_valid=1.
- Weights 127, bias 127, x=127 ×3 → t=3151 → y_out=127 (saturated).
- Hold y_ready=0 for 5 cycles after y_valid → y_out/y_valid stable; ack pulses ignored, acc unchanged. Then y_ready=1 for 1 cycle → IDLE, acc=0, idx=0.
- 4 acks before ack_mac rises → ovf=1 sticky, result equals the 3-sample value. Then rst → ovf=0, weights retained.
- rst asserted in BIAS → next cycle IDLE, y_valid=0. ack_mac held high by the counter produces no new rise until it drops and re-rises, so no spurious output.

Source files
------------

// File: rtl/nn_layer1_mac_neuron.sv
// Single layer-1 neuron: multiply-accumulate over N_IN samples, add bias, ReLU,
// saturate, then hand the result downstream on a valid/ready handshake.
module nn_layer1_mac_neuron #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned ACC_W  = 20,
  localparam int unsigned AW    = $clog2(N_IN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ack,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     ack_mac,
  input  logic                     w_wr,
  input  logic [AW-1:0]            w_addr,
  input  logic [DATA_W-1:0]        w_data,
  output logic [DATA_W-1:0]        y_out,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic                     busy,
  output logic                     ovf
);

  localparam int unsigned PW = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] MaxOut = ACC_W'((1 << (DATA_W - 1)) - 1);

  typedef enum logic [2:0] {StIdle, StAccum, StBias, StAct, StOut} state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic                      ack_mac_q;
  logic [DATA_W-1:0]         y_q, y_d;
  logic                      y_valid_q, y_valid_d;
  logic                      ovf_q, ovf_d;
  logic                      wr_en;

  // Coefficients are deliberately left out of reset so a reset keeps the loaded model.
  logic signed [DATA_W-1:0]  weight_q [N_IN];
  logic signed [DATA_W-1:0]  bias_q;

  logic                      rise;
  logic signed [DATA_W-1:0]  w_sel;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_sh;
  logic signed [ACC_W-1:0]   t;

  assign rise = ack_mac & ~ack_mac_q;

  // Weight for the current sample; idx only reaches N_IN once all samples are in.
  always_comb begin
    w_sel = '0;
    if (state_q == StIdle) begin
      w_sel = weight_q[0];
    end else if (idx_q < AW'(N_IN)) begin
      w_sel = weight_q[idx_q];
    end
  end

  assign prod     = x_in * w_sel;
  assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
  // Bias is aligned to the product format, which carries 2*FRAC_W fractional bits.
  assign bias_sh  = {{(ACC_W - DATA_W - FRAC_W){bias_q[DATA_W-1]}}, bias_q, {FRAC_W{1'b0}}};
  assign t        = acc_q >>> FRAC_W;

  // Next-state and datapath updates for the neuron sequencer.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    ovf_d     = ovf_q;
    wr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        wr_en = w_wr;
        if (ack) begin
          acc_d   = prod_ext;
          idx_d   = AW'(1);
          state_d = StAccum;
        end
        if (rise) state_d = StBias;
      end
      StAccum: begin
        if (ack) begin
          if (idx_q < AW'(N_IN)) begin
            acc_d = acc_q + prod_ext;
            idx_d = idx_q + AW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (rise) state_d = StBias;
      end
      StBias: begin
        acc_d   = acc_q + bias_sh;
        state_d = StAct;
      end
      StAct: begin
        if (t[ACC_W-1]) begin
          y_d = '0;
        end else if (t > MaxOut) begin
          y_d = MaxOut[DATA_W-1:0];
        end else begin
          y_d = t[DATA_W-1:0];
        end
        y_valid_d = 1'b1;
        state_d   = StOut;
      end
      StOut: begin
        if (y_ready) begin
          y_valid_d = 1'b0;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      idx_q     <= '0;
      ack_mac_q <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      ack_mac_q <= ack_mac;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  // Coefficient store, writable only while idle.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      if (w_addr < AW'(N_IN)) begin
        weight_q[w_addr] <= w_data;
      end else if (w_addr == AW'(N_IN)) begin
        bias_q <= w_data;
      end
    end
  end

  assign y_out   = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != StIdle);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_nn_layer1_mac_neuron.sv
// Scoreboard bench for nn_layer1_mac_neuron: stimulus pushes expected outputs,
// a monitor pops and compares on each new y_valid.
module tb_nn_layer1_mac_neuron;

  logic       clk = 1'b0;
  logic       rst, ack, ack_mac, w_wr, y_ready;
  logic [7:0] x_in, w_data;
  logic [1:0] w_addr;
  logic [7:0] y_out;
  logic       y_valid, busy, ovf;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  nn_layer1_mac_neuron dut (
    .clk     (clk),
    .rst     (rst),
    .ack     (ack),
    .x_in    (x_in),
    .ack_mac (ack_mac),
    .w_wr    (w_wr),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .y_out   (y_out),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: compare on the first cycle of each presented result.
  logic prev_valid = 1'b0;
  always @(posedge clk) begin
    #1;
    if (y_valid && !prev_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got %0d, required no output", y_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (y_out !== e) begin
          n_err++;
          $display("FAIL y_out: got %0d, required %0d", y_out, e);
        end
      end
    end
    prev_valid = y_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ack = 1'b0; ack_mac = 1'b0; w_wr = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    w_wr = 1'b1; w_addr = a; w_data = d;
    tick(1);
    w_wr = 1'b0;
  endtask

  task automatic sample(input logic [7:0] x);
    ack = 1'b1; x_in = x;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic load(input logic [7:0] w0, w1, w2, b);
    wr(2'd0, w0); wr(2'd1, w1); wr(2'd2, w2); wr(2'd3, b);
  endtask

  // Raise ack_mac and wait (bounded) for the result to appear.
  task automatic fire();
    int n;
    ack_mac = 1'b1;
    n = 0;
    while (!y_valid && n < 10) begin
      tick(1);
      n++;
    end
    if (!y_valid) begin
      n_cmp++; n_err++;
      $display("FAIL wait_valid: got no y_valid, required y_valid within 10 cycles");
    end
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; ack_mac = 1'b0; w_wr = 1'b0; y_ready = 1'b1;
    x_in = '0; w_addr = '0; w_data = '0;
    do_reset();
    chk("rst_y_out", y_out, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);

    // Nominal: 256+512-256=512, +256 bias = 768 -> 48; check latency.
    load(8'd16, 8'd32, 8'hF0, 8'd16);
    exp_q.push_back(8'd48);
    sample(8'd16);
    chk("busy_accum", busy, 1);
    sample(8'd16); sample(8'd16);
    ack_mac = 1'b1;
    tick(1);
    chk("lat_bias_valid", y_valid, 0);
    chk("lat_bias_busy", busy, 1);
    tick(1);
    chk("lat_act_valid", y_valid, 0);
    tick(1);
    chk("lat_out_valid", y_valid, 1);
    chk("lat_out_busy", busy, 1);
    tick(1);
    chk("post_busy", busy, 0);
    chk("post_valid", y_valid, 0);
    // ack_mac still high: no new rise, no new output.
    tick(4);
    chk("sticky_mac_idle", busy, 0);

    // ReLU: -768 -> t=-48 -> 0.
    do_reset();
    load(8'hF0, 8'hF0, 8'hF0, 8'd0);
    exp_q.push_back(8'd0);
    sample(8'd16); sample(8'd16); sample(8'd16);
    fire();
    tick(1);

    // Saturation: 3*16129 + 2032 = 50419 -> t=3151 -> 127.
    do_reset();
    load(8'd127, 8'd127, 8'd127, 8'd127);
    exp_q.push_back(8'd127);
    sample(8'd127); sample(8'd127); sample(8'd127);
    fire();
    tick(1);

    // Backpressure: 512+512+256 = 1280, +256 = 1536 -> 96.
    do_reset();
    load(8'd16, 8'd32, 8'hF0, 8'd16);
    y_ready = 1'b0;
    exp_q.push_back(8'd96);
    sample(8'd32); sample(8'd16); sample(8'hF0);
    fire();
    for (int i = 0; i < 5; i++) begin
      ack = 1'b1; x_in = 8'd16;
      tick(1);
      chk("hold_valid", y_valid, 1);
      chk("hold_y_out", y_out, 96);
    end
    ack = 1'b0;
    y_ready = 1'b1;
    tick(1);
    chk("release_valid", y_valid, 0);
    chk("release_busy", busy, 0);
    // Fresh rise without reset: acc/idx must have been cleared.
    ack_mac = 1'b0;
    tick(1);
    exp_q.push_back(8'd48);
    sample(8'd16); sample(8'd16); sample(8'd16);
    fire();
    tick(1);

    // Overflow: 4th ack ignored but flagged; write in ACCUM ignored.
    do_reset();
    exp_q.push_back(8'd48);
    sample(8'd16);
    wr(2'd2, 8'd100);
    sample(8'd16); sample(8'd16);
    chk("ovf_before", ovf, 0);
    sample(8'd16);
    chk("ovf_set", ovf, 1);
    fire();
    tick(1);
    chk("ovf_sticky", ovf, 1);
    do_reset();
    chk("ovf_cleared", ovf, 0);
    // Weights survive reset.
    exp_q.push_back(8'd48);
    sample(8'd16); sample(8'd16); sample(8'd16);
    fire();
    tick(1);

    // Reset in BIAS (with a simultaneous ack): result discarded.
    do_reset();
    sample(8'd16); sample(8'd16); sample(8'd16);
    ack_mac = 1'b1;
    tick(1);
    chk("in_bias_busy", busy, 1);
    rst = 1'b1; ack = 1'b1; x_in = 8'd16; ack_mac = 1'b0;
    tick(1);
    rst = 1'b0; ack = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", y_valid, 0);
    chk("abort_y_out", y_out, 0);
    tick(6);
    chk("abort_quiet", busy, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
